// File: rtl/csa_pipe.sv
// csa_pipe: pipelined carry-select adder/subtractor with valid/ready handshake.
// An input rank captures the operands; then NBLK stages each resolve one BLK-bit
// slice, choosing between precomputed carry-in 0 and carry-in 1 results with the
// carry registered by the previous rank. Unconsumed operand bits shift down the
// pipe alongside each stage, and finished sum slices are carried forward so that
// the full result leaves the last rank aligned.
module csa_pipe #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLK;

    // Rank r of the pipe is exposed through index r of these buses: rank 0 is the
    // operand capture, rank i+1 is written by stage i, rank NBLK drives the outputs.
    logic             w_advance;
    logic [NBLK:0]    w_validQ;
    logic [NBLK:0]    w_carryQ;
    logic [WIDTH-1:0] w_opAQ [NBLK+1];
    logic [WIDTH-1:0] w_opBQ [NBLK+1];
    logic [WIDTH-1:0] w_sumQ [NBLK+1];
    logic [NBLK-1:0]  w_ovfQ;
    logic             w_unused;

    logic             r_inValid;
    logic             r_inCarry;
    logic [WIDTH-1:0] r_inA;
    logic [WIDTH-1:0] r_inB;

    // The whole pipe moves together; it only freezes while a finished result waits
    // for a downstream that is not ready.
    assign w_advance = !(out_valid && !out_ready);
    assign in_ready  = w_advance;

    // Capture operands, pre-inverting y and forcing the carry-in to 1 for subtraction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inValid <= 1'b0;
            r_inCarry <= 1'b0;
            r_inA     <= '0;
            r_inB     <= '0;
        end else if (w_advance) begin
            r_inValid <= in_valid;
            if (in_valid) begin
                r_inA     <= x;
                r_inB     <= sub ? ~y : y;
                r_inCarry <= sub | cin;
            end
        end
    end

    assign w_validQ[0] = r_inValid;
    assign w_carryQ[0] = r_inCarry;
    assign w_opAQ[0]   = r_inA;
    assign w_opBQ[0]   = r_inB;
    assign w_sumQ[0]   = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_stage
            logic [BLK-1:0]   w_blkA;
            logic [BLK-1:0]   w_blkB;
            logic [BLK-1:0]   w_blkS;
            logic [BLK:0]     w_sum0;
            logic [BLK:0]     w_sum1;
            logic             w_blkCarry;
            logic             w_blkOvf;
            logic [WIDTH-1:0] w_mergedSum;
            logic             r_valid;
            logic             r_carry;
            logic             r_ovf;
            logic [WIDTH-1:0] r_opA;
            logic [WIDTH-1:0] r_opB;
            logic [WIDTH-1:0] r_sum;

            // The operands have already been shifted, so this stage's slice is
            // always the low BLK bits of what the previous rank holds.
            assign w_blkA = w_opAQ[gi][BLK-1:0];
            assign w_blkB = w_opBQ[gi][BLK-1:0];
            assign w_sum0 = {1'b0, w_blkA} + {1'b0, w_blkB};
            assign w_sum1 = {1'b0, w_blkA} + {1'b0, w_blkB} + (BLK+1)'(1);
            assign {w_blkCarry, w_blkS} = w_carryQ[gi] ? w_sum1 : w_sum0;

            // Carry into the slice MSB is a^b^s there; overflow when it differs
            // from the carry out. Only the top stage's value reaches ovf.
            assign w_blkOvf = w_blkA[BLK-1] ^ w_blkB[BLK-1] ^ w_blkS[BLK-1] ^ w_blkCarry;

            // Drop the freshly resolved slice into the partial sum from upstream
            always_comb begin
                w_mergedSum                  = w_sumQ[gi];
                w_mergedSum[gi*BLK +: BLK]   = w_blkS;
            end

            // Register this stage's slice result and pass the remaining operand bits on
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_carry <= 1'b0;
                    r_ovf   <= 1'b0;
                    r_opA   <= '0;
                    r_opB   <= '0;
                    r_sum   <= '0;
                end else if (w_advance) begin
                    r_valid <= w_validQ[gi];
                    if (w_validQ[gi]) begin
                        r_carry <= w_blkCarry;
                        r_ovf   <= w_blkOvf;
                        r_sum   <= w_mergedSum;
                        r_opA   <= w_opAQ[gi] >> BLK;
                        r_opB   <= w_opBQ[gi] >> BLK;
                    end
                end
            end

            assign w_validQ[gi+1] = r_valid;
            assign w_carryQ[gi+1] = r_carry;
            assign w_opAQ[gi+1]   = r_opA;
            assign w_opBQ[gi+1]   = r_opB;
            assign w_sumQ[gi+1]   = r_sum;
            assign w_ovfQ[gi]     = r_ovf;
        end
    endgenerate

    assign out_valid = w_validQ[NBLK];
    assign s         = w_sumQ[NBLK];
    assign cout      = w_carryQ[NBLK];
    assign ovf       = w_ovfQ[NBLK-1];

    // The last rank's operand remnants are always zero and the lower stages'
    // overflow flags are never needed; fold them into a sink so nothing dangles.
    assign w_unused = ^{w_opAQ[NBLK], w_opBQ[NBLK], w_ovfQ};

endmodule

// File: tb/tb_csa_pipe.sv
// tb_csa_pipe: directed and randomized checks of csa_pipe at 32/8, 16/4, 12/12 and 8/1.
// A queue-based scoreboard per instance predicts every result from plain arithmetic.
module tb_csa_pipe;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [31:0] x         = '0;
    logic [31:0] y         = '0;
    logic        cin       = 1'b0;
    logic        sub       = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy0, ov0, co0, of0;
    logic [31:0] s0;
    logic        rdy1, ov1, co1, of1;
    logic [15:0] s1;
    logic        rdy2, ov2, co2, of2;
    logic [11:0] s2;
    logic        rdy3, ov3, co3, of3;
    logic [7:0]  s3;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [33:0] q0[$];
    logic [33:0] q1[$];
    logic [33:0] q2[$];
    logic [33:0] q3[$];

    always #5 clk = ~clk;

    csa_pipe #(.WIDTH(32), .BLK(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready),
        .s(s0), .cout(co0), .ovf(of0)
    );

    csa_pipe #(.WIDTH(16), .BLK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .x(x[15:0]), .y(y[15:0]), .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
        .s(s1), .cout(co1), .ovf(of1)
    );

    csa_pipe #(.WIDTH(12), .BLK(12)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .x(x[11:0]), .y(y[11:0]), .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(out_ready),
        .s(s2), .cout(co2), .ovf(of2)
    );

    csa_pipe #(.WIDTH(8), .BLK(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
        .x(x[7:0]), .y(y[7:0]), .cin(cin), .sub(sub), .out_valid(ov3), .out_ready(out_ready),
        .s(s3), .cout(co3), .ovf(of3)
    );

    // Count one comparison and report it if the observed value is not the expected one
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one set of operands onto the shared input bus
    task automatic applyStimulus(input logic v, input logic [31:0] xv, input logic [31:0] yv,
                                 input logic c, input logic sb);
        in_valid = v;
        x        = xv;
        y        = yv;
        cin      = c;
        sub      = sb;
    endtask

    // Reference result {ovf, cout, s} for a w-bit add/subtract done with wide arithmetic
    function automatic logic [33:0] refModel(input int w, input logic [31:0] xv, input logic [31:0] yv,
                                             input logic c, input logic sb);
        logic [31:0] mask;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] full;
        logic        co;
        logic        ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        a    = xv & mask;
        b    = (sb ? ~yv : yv) & mask;
        full = {1'b0, a} + {1'b0, b} + {32'b0, (sb ? 1'b1 : c)};
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
        return {ov, co, full[31:0] & mask};
    endfunction

    // Random operand with a bias towards the corner values that stress carries and signs
    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_7FFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard for the 32/8 instance: head of queue must sit on the output until it retires
    always @(negedge clk) begin
        if (!rst_n) q0.delete();
        else begin
            checkOutput("p0 in_ready", 64'(rdy0), 64'(!(ov0 && !out_ready)));
            if (ov0) begin
                if (q0.size() == 0) checkOutput("p0 spurious out_valid", 64'(ov0), 64'(0));
                else begin
                    checkOutput("p0 result", 64'({of0, co0, s0}), 64'(q0[0]));
                    if (out_ready) q0.delete(0);
                end
            end
            if (in_valid && rdy0) q0.push_back(refModel(32, x, y, cin, sub));
        end
    end

    // Scoreboard for the 16/4 instance
    always @(negedge clk) begin
        if (!rst_n) q1.delete();
        else begin
            checkOutput("p1 in_ready", 64'(rdy1), 64'(!(ov1 && !out_ready)));
            if (ov1) begin
                if (q1.size() == 0) checkOutput("p1 spurious out_valid", 64'(ov1), 64'(0));
                else begin
                    checkOutput("p1 result", 64'({of1, co1, s1}), 64'({q1[0][33:32], q1[0][15:0]}));
                    if (out_ready) q1.delete(0);
                end
            end
            if (in_valid && rdy1) q1.push_back(refModel(16, x, y, cin, sub));
        end
    end

    // Scoreboard for the 12/12 instance (single stage)
    always @(negedge clk) begin
        if (!rst_n) q2.delete();
        else begin
            checkOutput("p2 in_ready", 64'(rdy2), 64'(!(ov2 && !out_ready)));
            if (ov2) begin
                if (q2.size() == 0) checkOutput("p2 spurious out_valid", 64'(ov2), 64'(0));
                else begin
                    checkOutput("p2 result", 64'({of2, co2, s2}), 64'({q2[0][33:32], q2[0][11:0]}));
                    if (out_ready) q2.delete(0);
                end
            end
            if (in_valid && rdy2) q2.push_back(refModel(12, x, y, cin, sub));
        end
    end

    // Scoreboard for the 8/1 instance (bit-serial carry, eight stages)
    always @(negedge clk) begin
        if (!rst_n) q3.delete();
        else begin
            checkOutput("p3 in_ready", 64'(rdy3), 64'(!(ov3 && !out_ready)));
            if (ov3) begin
                if (q3.size() == 0) checkOutput("p3 spurious out_valid", 64'(ov3), 64'(0));
                else begin
                    checkOutput("p3 result", 64'({of3, co3, s3}), 64'({q3[0][33:32], q3[0][7:0]}));
                    if (out_ready) q3.delete(0);
                end
            end
            if (in_valid && rdy3) q3.push_back(refModel(8, x, y, cin, sub));
        end
    end

    // One operation into an empty 32/8 pipe: nothing after 3 edges, the result after 4
    task automatic runSingle(input string tag, input logic releaseReset,
                             input logic [31:0] xv, input logic [31:0] yv, input logic c, input logic sb,
                             input logic [31:0] expS, input logic expC, input logic expO);
        @(posedge clk); #1;
        if (releaseReset) rst_n = 1'b1;
        applyStimulus(1'b1, xv, yv, c, sb);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " early valid"}, 64'(ov0), 64'(0));
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " valid"}, 64'(ov0), 64'(1));
        checkOutput({tag, " s"}, 64'(s0), 64'(expS));
        checkOutput({tag, " cout"}, 64'(co0), 64'(expC));
        checkOutput({tag, " ovf"}, 64'(of0), 64'(expO));
    endtask

    initial begin
        // Watchdog: the run never legitimately gets near this
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d", compareCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int next;
        int outIdx;
        int cyc;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset out_valid", 64'(ov0), 64'(0));
        checkOutput("reset s", 64'(s0), 64'(0));
        checkOutput("reset cout", 64'(co0), 64'(0));
        checkOutput("reset ovf", 64'(of0), 64'(0));
        checkOutput("reset in_ready", 64'(rdy0), 64'(1));
        repeat (2) @(posedge clk);

        // Full-width carry ripple, accepted on the first edge after reset release
        runSingle("ripple", 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        runSingle("sub 5-7", 1'b0, 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        runSingle("signed ovf", 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        // Back-to-back stream, full throughput: results 0x11..0x16 after edges 5..10
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c < 6) applyStimulus(1'b1, 32'(c + 1), 32'h10, 1'b0, 1'b0);
            else       applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("stream valid", 64'(ov0), 64'(c >= 5 && c <= 10));
            if (c >= 5 && c <= 10) checkOutput("stream s", 64'(s0), 64'(32'h11 + c - 5));
        end

        // Same stream with the downstream stalling in cycles 5..8
        next   = 0;
        outIdx = 0;
        cyc    = 0;
        while (outIdx < 6 && cyc < 40) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 5 && cyc <= 8);
            if (next < 6) applyStimulus(1'b1, 32'(next + 1), 32'h10, 1'b0, 1'b0);
            else          applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (cyc >= 5 && cyc <= 8) begin
                checkOutput("stall in_ready", 64'(rdy0), 64'(0));
                checkOutput("stall valid", 64'(ov0), 64'(1));
                checkOutput("stall s held", 64'(s0), 64'(32'h11));
            end
            if (ov0) begin
                checkOutput("stall order s", 64'(s0), 64'(32'h11 + outIdx));
                if (out_ready) outIdx++;
            end
            if (in_valid && rdy0) next++;
            cyc++;
        end
        checkOutput("stall results delivered", 64'(outIdx), 64'(6));
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (12) @(posedge clk);

        // Reset with one result on the output and three operations in flight
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c < 4) applyStimulus(1'b1, 32'(c + 32'h20), 32'h0, 1'b0, 1'b0);
            else       applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        checkOutput("pre-reset valid", 64'(ov0), 64'(1));
        checkOutput("pre-reset s", 64'(s0), 64'(32'h20));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid reset valid", 64'(ov0), 64'(0));
        checkOutput("mid reset s", 64'(s0), 64'(0));
        checkOutput("mid reset in_ready", 64'(rdy0), 64'(1));
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("no stale result", 64'(ov0), 64'(0));
        end
        runSingle("add 2+3", 1'b0, 32'd2, 32'd3, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0);

        // Randomized regression across all four configurations with random backpressure
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            applyStimulus(1'($urandom_range(0, 3) != 0), pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 3) != 0);
        end

        // Drain everything still in flight
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkOutput("p0 drained", 64'(q0.size()), 64'(0));
        checkOutput("p1 drained", 64'(q1.size()), 64'(0));
        checkOutput("p2 drained", 64'(q2.size()), 64'(0));
        checkOutput("p3 drained", 64'(q3.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
